posit_add_issue: RTL and testbench

- Sequential issue/retire stage wrapped around the combinational 16-bit posit adder (PositAdd); sits directly upstream of it and consumes its result.
- Buffers operand requests in a small in-order FIFO with valid/ready handshake and presents the head entry to the adder.
- Captures the adder result plus flags and a request tag into a registered response slot with its own valid/ready handshake.
- Gives the combinational adder a pipelined, back-pressurable interface for the SoC bus wrapper.

---
 rtl/posit_add_issue.sv | 146 ++++++++++++++
 tb/tb_posit_add_issue.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_add_issue.sv
// posit_add_issue: in-order request FIFO plus registered response slot around PositAdd.
// Define POSIT_ADD_ISSUE_STATS_EN to add the stat_ops / stat_nar retire counters.
module posit_add_issue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [15:0]      req_num1,
  input  logic [15:0]      req_num2,
  input  logic             req_sub,
  input  logic [TAG_W-1:0] req_tag,
  output logic [15:0]      add_num1,
  output logic [15:0]      add_num2,
  output logic             add_sub,
  input  logic [15:0]      add_out,
  input  logic             add_isZero,
  input  logic             add_isNaR,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_out,
  output logic             rsp_isZero,
  output logic             rsp_isNaR,
  output logic [TAG_W-1:0] rsp_tag,
`ifdef POSIT_ADD_ISSUE_STATS_EN
  output logic [31:0]      stat_ops,
  output logic [15:0]      stat_nar,
  output logic [$clog2(DEPTH):0] fifo_count
`else
  output logic [$clog2(DEPTH):0] fifo_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [15:0]      num1;
    logic [15:0]      num2;
    logic             sub;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t           r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_rsp_valid;
  logic [15:0]      r_rsp_out;
  logic             r_rsp_zero;
  logic             r_rsp_nar;
  logic [TAG_W-1:0] r_rsp_tag;

  entry_t w_head;
  entry_t w_wdata;
  logic   w_full;
  logic   w_empty;
  logic   w_push;
  logic   w_pop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = req_valid && !w_full;
  assign w_pop   = !w_empty && (!r_rsp_valid || rsp_ready);
  assign w_head  = r_mem[r_rptr];
  assign w_wdata = {req_num1, req_num2, req_sub, req_tag};

  // Storage needs no reset: the pointers decide what is live.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      unique case (1'b1)
        (w_push && !w_pop): r_count <= r_count + CW'(1);
        (w_pop && !w_push): r_count <= r_count - CW'(1);
        default:            r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_out   <= '0;
      r_rsp_zero  <= 1'b0;
      r_rsp_nar   <= 1'b0;
      r_rsp_tag   <= '0;
    end else if (w_pop) begin
      r_rsp_valid <= 1'b1;
      r_rsp_out   <= add_out;
      r_rsp_zero  <= add_isZero;
      r_rsp_nar   <= add_isNaR;
      r_rsp_tag   <= w_head.tag;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

`ifdef POSIT_ADD_ISSUE_STATS_EN
  logic [31:0] r_ops;
  logic [15:0] r_nar;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_ops <= '0;
      r_nar <= '0;
    end else if (w_pop) begin
      r_ops <= r_ops + 32'd1;
      if (add_isNaR) begin
        r_nar <= r_nar + 16'd1;
      end
    end
  end

  assign stat_ops = r_ops;
  assign stat_nar = r_nar;
`endif

  assign req_ready  = !w_full;
  assign add_num1   = w_empty ? 16'h0000 : w_head.num1;
  assign add_num2   = w_empty ? 16'h0000 : w_head.num2;
  assign add_sub    = w_empty ? 1'b0 : w_head.sub;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_out    = r_rsp_out;
  assign rsp_isZero = r_rsp_zero;
  assign rsp_isNaR  = r_rsp_nar;
  assign rsp_tag    = r_rsp_tag;
  assign fifo_count = r_count;

endmodule

// File: tb/tb_posit_add_issue.sv
// tb_posit_add_issue: directed vectors, backpressure, streaming, random
// traffic against a queue model, with a behavioural posit16 (es=1) adder.
module tb_posit_add_issue;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             req_valid;
  logic             req_ready;
  logic [15:0]      req_num1;
  logic [15:0]      req_num2;
  logic             req_sub;
  logic [TAG_W-1:0] req_tag;
  logic [15:0]      add_num1;
  logic [15:0]      add_num2;
  logic             add_sub;
  logic [15:0]      add_out;
  logic             add_isZero;
  logic             add_isNaR;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [15:0]      rsp_out;
  logic             rsp_isZero;
  logic             rsp_isNaR;
  logic [TAG_W-1:0] rsp_tag;
  logic [2:0]       fifo_count;
`ifdef POSIT_ADD_ISSUE_STATS_EN
  logic [31:0]      stat_ops;
  logic [15:0]      stat_nar;
`endif

  always #5 clock = ~clock;

  posit_add_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_num1(req_num1), .req_num2(req_num2),
    .req_sub(req_sub), .req_tag(req_tag),
    .add_num1(add_num1), .add_num2(add_num2), .add_sub(add_sub),
    .add_out(add_out), .add_isZero(add_isZero), .add_isNaR(add_isNaR),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_out(rsp_out), .rsp_isZero(rsp_isZero),
    .rsp_isNaR(rsp_isNaR), .rsp_tag(rsp_tag),
`ifdef POSIT_ADD_ISSUE_STATS_EN
    .stat_ops(stat_ops), .stat_nar(stat_nar),
`endif
    .fifo_count(fifo_count)
  );

  function automatic real pow2(input int n);
    real s;
    s = 1.0;
    if (n >= 0) repeat (n) s = s * 2.0;
    else repeat (-n) s = s / 2.0;
    return s;
  endfunction

  function automatic real p2r(input logic [15:0] p);
    logic [15:0] v;
    logic r;
    logic e;
    int m;
    int k;
    real f;
    if (p == 16'h0000) return 0.0;
    v = p[15] ? (~p + 16'd1) : p;
    v = v << 1;
    r = v[15];
    m = 0;
    while (m < 15 && v[15] == r) begin
      v = v << 1;
      m++;
    end
    v = v << 1;
    k = r ? m - 1 : -m;
    e = v[15];
    v = v << 1;
    f = (1.0 + real'(v) / 65536.0) * pow2(2 * k + int'(e));
    return p[15] ? -f : f;
  endfunction

  function automatic logic [15:0] r2p(input real xin);
    real x;
    real f;
    logic neg;
    int sc;
    int k;
    int e;
    int pos;
    logic [63:0] bs;
    logic [15:0] body;
    logic rb;
    logic st;
    if (xin == 0.0) return 16'h0000;
    neg = xin < 0.0;
    x = neg ? -xin : xin;
    if (x >= 268435456.0) body = 16'h7fff;
    else if (x <= 1.0 / 268435456.0) body = 16'h0001;
    else begin
      sc = 0;
      while (x >= 2.0) begin x = x / 2.0; sc++; end
      while (x < 1.0) begin x = x * 2.0; sc--; end
      k = (sc >= 0) ? sc / 2 : -((1 - sc) / 2);
      e = sc - 2 * k;
      bs = '0;
      pos = 63;
      if (k >= 0) begin
        for (int i = 0; i <= k; i++) begin bs[pos] = 1'b1; pos--; end
        pos--;
      end else begin
        pos = pos + k;
        bs[pos] = 1'b1;
        pos--;
      end
      bs[pos] = (e != 0);
      pos--;
      f = x - 1.0;
      while (pos >= 0) begin
        f = f * 2.0;
        if (f >= 1.0) begin bs[pos] = 1'b1; f = f - 1.0; end
        pos--;
      end
      body = {1'b0, bs[63:49]};
      rb = bs[48];
      st = (|bs[47:0]) || (f > 0.0);
      if (rb && (st || body[0])) body = body + 16'd1;
      if (body[15]) body = 16'h7fff;
    end
    return neg ? (~body + 16'd1) : body;
  endfunction

  // Result packed as {out, isZero, isNaR}
  function automatic logic [17:0] padd(input logic [15:0] a,
                                       input logic [15:0] b,
                                       input logic s);
    logic [15:0] o;
    real x;
    if (a == 16'h8000 || b == 16'h8000) return {16'h8000, 1'b0, 1'b1};
    x = s ? p2r(a) - p2r(b) : p2r(a) + p2r(b);
    o = r2p(x);
    return {o, (o == 16'h0000), 1'b0};
  endfunction

  logic [17:0] add_res;
  always_comb begin
    add_res = padd(add_num1, add_num2, add_sub);
  end
  assign add_out    = add_res[17:2];
  assign add_isZero = add_res[1];
  assign add_isNaR  = add_res[0];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [3:0]  tag;
    logic [15:0] eo;
    logic        ez;
    logic        en;
  } vec_t;

  typedef struct {
    logic [15:0] o;
    logic        z;
    logic        n;
    logic [3:0]  tag;
  } rsp_t;

  rsp_t q[$];
  int   n_pass = 0;
  int   n_tot = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_num1  = '0;
    req_num2  = '0;
    req_sub   = 1'b0;
    req_tag   = '0;
  endtask

  task automatic rand_req();
    int sel;
    sel = $urandom_range(0, 15);
    req_num1 = (sel == 0) ? 16'h8000 : 16'($urandom);
    req_num2 = (sel == 1) ? 16'h0000 : 16'($urandom);
    req_sub  = 1'($urandom);
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    q.delete();
  endtask

  // Inputs already set at a negedge; account handshakes, advance one cycle
  task automatic cycle();
    rsp_t e;
    logic [17:0] r;
    #1;
    if (req_valid && req_ready) begin
      r = padd(req_num1, req_num2, req_sub);
      e.o = r[17:2];
      e.z = r[1];
      e.n = r[0];
      e.tag = req_tag;
      q.push_back(e);
    end
    if (rsp_valid && rsp_ready) begin
      if (q.size() == 0) chk("rsp_spurious", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        chk("rsp_out", rsp_out, e.o);
        chk("rsp_flags", {rsp_isZero, rsp_isNaR}, {e.z, e.n});
        chk("rsp_tag", rsp_tag, e.tag);
      end
    end
    chk("occupancy", 32'(q.size() <= DEPTH + 1), 32'd1);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drain();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int n = 0; n < 20 && q.size() != 0; n++) cycle();
    chk("drain_empty", q.size(), 32'd0);
    chk("drain_valid", rsp_valid, 1'b0);
  endtask

  vec_t tv[6];
  int   nar_cnt;
  int   maxc;

  initial begin
    tv[0] = '{16'h4000, 16'h4000, 1'b0, 4'd3,  16'h5000, 1'b0, 1'b0};
    tv[1] = '{16'h4000, 16'h4000, 1'b1, 4'd5,  16'h0000, 1'b1, 1'b0};
    tv[2] = '{16'h8000, 16'h4000, 1'b0, 4'd9,  16'h8000, 1'b0, 1'b1};
    tv[3] = '{16'h3000, 16'h3000, 1'b0, 4'd12, 16'h4000, 1'b0, 1'b0};
    tv[4] = '{16'h4000, 16'h5000, 1'b1, 4'd15, 16'hC000, 1'b0, 1'b0};
    tv[5] = '{16'h0000, 16'h0000, 1'b0, 4'd0,  16'h0000, 1'b1, 1'b0};

    idle();
    rsp_ready = 1'b1;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_out", rsp_out, 16'h0);
    chk("rst_rsp_flags", {rsp_isZero, rsp_isNaR}, 2'b00);
    chk("rst_rsp_tag", rsp_tag, 4'h0);
    chk("rst_count", fifo_count, 3'd0);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_add_drive", {add_num1, add_num2, add_sub}, 33'h0);
    reset = 1'b1;

    nar_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1;
      req_num1  = tv[i].a;
      req_num2  = tv[i].b;
      req_sub   = tv[i].s;
      req_tag   = tv[i].tag;
      #1;
      chk("vec_req_ready", req_ready, 1'b1);
      @(posedge clock);
      @(negedge clock);
      idle();
      chk("vec_lat1_valid", rsp_valid, 1'b0);
      chk("vec_head_num1", add_num1, tv[i].a);
      chk("vec_head_count", fifo_count, 3'd1);
      @(posedge clock);
      @(negedge clock);
      chk("vec_lat2_valid", rsp_valid, 1'b1);
      chk("vec_out", rsp_out, tv[i].eo);
      chk("vec_zero", rsp_isZero, tv[i].ez);
      chk("vec_nar", rsp_isNaR, tv[i].en);
      chk("vec_tag", rsp_tag, tv[i].tag);
      chk("vec_count", fifo_count, 3'd0);
      if (tv[i].en) nar_cnt++;
`ifdef POSIT_ADD_ISSUE_STATS_EN
      chk("stat_ops", stat_ops, 32'(i + 1));
      chk("stat_nar", stat_nar, 16'(nar_cnt));
`endif
    end
    @(posedge clock);
    @(negedge clock);
    chk("vec_drained", rsp_valid, 1'b0);
    chk("vec_hold_out", rsp_out, 16'h0000);

    do_reset();
    rsp_ready = 1'b0;
    for (int t = 0; t < 7; t++) begin
      req_valid = 1'b1;
      rand_req();
      req_tag = TAG_W'(t);
      cycle();
    end
    idle();
    chk("bp_accepted", q.size(), 32'd5);
    chk("bp_req_ready", req_ready, 1'b0);
    chk("bp_count", fifo_count, 3'd4);
    chk("bp_valid", rsp_valid, 1'b1);
    chk("bp_tag0", rsp_tag, 4'd0);
    for (int h = 0; h < 3; h++) begin
      cycle();
      chk("bp_hold_tag", rsp_tag, 4'd0);
      chk("bp_hold_out", rsp_out, q[0].o);
    end
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_tag = 4'hF;
    cycle();
    idle();
    chk("bp_full_nopush", fifo_count, 3'd3);
    for (int i = 1; i < 5; i++) begin
      chk("bp_drain_valid", rsp_valid, 1'b1);
      chk("bp_drain_tag", rsp_tag, 4'(i));
      cycle();
    end
    chk("bp_end_valid", rsp_valid, 1'b0);
    chk("bp_end_q", q.size(), 32'd0);

    do_reset();
    rsp_ready = 1'b1;
    maxc = 0;
    for (int c = 0; c < 19; c++) begin
      req_valid = (c < 16);
      rand_req();
      req_tag = TAG_W'(c);
      chk("stream_valid", rsp_valid, 1'((c >= 2) && (c <= 17)));
      if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
      cycle();
    end
    idle();
    chk("stream_maxcount", maxc, 32'd1);
    chk("stream_q", q.size(), 32'd0);

    for (int c = 0; c < 300; c++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      rsp_ready = ($urandom_range(0, 2) != 0);
      rand_req();
      req_tag = TAG_W'($urandom);
      cycle();
    end
    drain();

    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1;
      rand_req();
      req_tag = TAG_W'(i);
      cycle();
    end
    idle();
    chk("mid_valid", rsp_valid, 1'b1);
    chk("mid_count", fifo_count, 3'd3);
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    q.delete();
    chk("mid_rst_valid", rsp_valid, 1'b0);
    chk("mid_rst_count", fifo_count, 3'd0);
    chk("mid_rst_ready", req_ready, 1'b1);
    chk("mid_rst_num1", add_num1, 16'h0000);
    chk("mid_rst_tag", rsp_tag, 4'h0);
`ifdef POSIT_ADD_ISSUE_STATS_EN
    chk("mid_rst_ops", stat_ops, 32'd0);
`endif
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("no_stale", rsp_valid, 1'b0);
      @(posedge clock);
      @(negedge clock);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
